// File: rtl/vga_timing_if.sv
// vga_timing_if - raster timing bundle from the timing generator to the
// background-draw stage.
//
// Signals:
//   hcount, vcount  12-bit pixel / line counters
//   hsync, vsync    active-high sync flags aligned with the counts
//   hblnk, vblnk    blanking flags aligned with the counts
//   frame_start     one-cycle pulse at (0,0); only when VGA_FRAME_START_EN
//                   is defined
//
// Modports: master (timing generator drives), slave (consumer reads).
interface vga_timing_if;
  logic [11:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] hcount;
  logic        hsync;
  logic        hblnk;
`ifdef VGA_FRAME_START_EN
  logic        frame_start;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, frame_start);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, frame_start);
`else
  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
`endif
endinterface

// File: rtl/vga_timing.sv
// vga_timing - free-running raster timing generator, XGA 1024x768 @ 60 Hz
// (65 MHz pixel clock) by default.
//
// Ports:
//   clk  in   pixel clock
//   rst  in   synchronous, active-high reset (priority over counting)
//   vga  out  vga_timing_if.master: hcount/vcount plus hsync/hblnk/vsync/vblnk,
//             and frame_start when VGA_FRAME_START_EN is defined
//
// Optional feature macro: VGA_FRAME_START_EN adds the frame_start pulse,
// high for one cycle whenever (0,0) is presented by a natural wrap (never
// right after reset release).
//
// Every output is a register. Flags are decoded from the next-state counts
// and registered together with them, so a flag always describes the count
// values visible in the same cycle. Syncs are active-high here; the pin
// level inverts them for the negative-polarity XGA mode.
module vga_timing #(
  parameter int H_ACTIVE     = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_WIDTH = 136,
  parameter int H_TOTAL      = 1344,
  parameter int V_ACTIVE     = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_WIDTH = 6,
  parameter int V_TOTAL      = 806
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_BLNK_BEG = 12'(H_ACTIVE);
  localparam logic [11:0] V_BLNK_BEG = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_SYNC_START);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_SYNC_START);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC_START + V_SYNC_WIDTH);

  logic [11:0] hcount_reg, hcount_next;
  logic [11:0] vcount_reg, vcount_next;
  logic        hsync_reg,  hsync_next;
  logic        hblnk_reg,  hblnk_next;
  logic        vsync_reg,  vsync_next;
  logic        vblnk_reg,  vblnk_next;
  logic        h_wrap;
  logic        v_wrap;

  always_comb begin
    h_wrap = (hcount_reg == H_LAST);
    v_wrap = (vcount_reg == V_LAST);

    hcount_next = h_wrap ? 12'd0 : hcount_reg + 12'd1;
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = v_wrap ? 12'd0 : vcount_reg + 12'd1;
    end

    // Decode from the counts that will be presented next cycle so flags
    // and counts leave the registers together.
    hblnk_next = (hcount_next >= H_BLNK_BEG);
    hsync_next = (hcount_next >= H_SYNC_BEG) && (hcount_next < H_SYNC_END);
    vblnk_next = (vcount_next >= V_BLNK_BEG);
    vsync_next = (vcount_next >= V_SYNC_BEG) && (vcount_next < V_SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_reg <= 12'd0;
      vcount_reg <= 12'd0;
      hsync_reg  <= 1'b0;
      hblnk_reg  <= 1'b0;
      vsync_reg  <= 1'b0;
      vblnk_reg  <= 1'b0;
    end else begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      hsync_reg  <= hsync_next;
      hblnk_reg  <= hblnk_next;
      vsync_reg  <= vsync_next;
      vblnk_reg  <= vblnk_next;
    end
  end

  assign vga.hcount = hcount_reg;
  assign vga.vcount = vcount_reg;
  assign vga.hsync  = hsync_reg;
  assign vga.hblnk  = hblnk_reg;
  assign vga.vsync  = vsync_reg;
  assign vga.vblnk  = vblnk_reg;

`ifdef VGA_FRAME_START_EN
  logic frame_start_reg;
  logic frame_start_next;

  // Only the natural wrap out of the last pixel of the last line produces
  // the pulse; the (0,0) shown after a reset does not.
  assign frame_start_next = h_wrap && v_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_start_next;
    end
  end

  assign vga.frame_start = frame_start_reg;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one XGA-geometry instance and one reduced-geometry
// instance (so whole frames fit in a short run), both sharing clk/rst.
// A raster model derived from elapsed cycles since reset is compared against
// both instances every cycle; directed literal checks pin the model.
module tb_vga_timing;

  // Reduced geometry: 56 px/line, 25 lines/frame -> 1400 clks/frame.
  localparam int SH_ACT = 40, SH_SS = 44, SH_SW = 8, SH_TOT = 56;
  localparam int SV_ACT = 20, SV_SS = 22, SV_SW = 3, SV_TOT = 25;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  logic clk;
  logic rst;

  vga_timing_if vga_x ();
  vga_timing_if vga_s ();

  vga_timing dut_xga (
    .clk (clk),
    .rst (rst),
    .vga (vga_x)
  );

  vga_timing #(
    .H_ACTIVE(SH_ACT), .H_SYNC_START(SH_SS), .H_SYNC_WIDTH(SH_SW), .H_TOTAL(SH_TOT),
    .V_ACTIVE(SV_ACT), .V_SYNC_START(SV_SS), .V_SYNC_WIDTH(SV_SW), .V_TOTAL(SV_TOT)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .vga (vga_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic finish_up();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      if (n_fail >= 200) finish_up();
    end
  endtask

  // Packed view {frame_start, vblnk, vsync, hblnk, hsync, vcount, hcount}.
  logic fs_x, fs_s;
`ifdef VGA_FRAME_START_EN
  assign fs_x = vga_x.frame_start;
  assign fs_s = vga_s.frame_start;
`else
  assign fs_x = 1'b0;
  assign fs_s = 1'b0;
`endif
  logic [28:0] act_x, act_s;
  assign act_x = {fs_x, vga_x.vblnk, vga_x.vsync, vga_x.hblnk, vga_x.hsync, vga_x.vcount, vga_x.hcount};
  assign act_s = {fs_s, vga_s.vblnk, vga_s.vsync, vga_s.hblnk, vga_s.hsync, vga_s.vcount, vga_s.hcount};

  // Raster position is a pure function of clocks elapsed since reset.
  function automatic logic [28:0] model(input int t, input int ha, input int hss, input int hsw,
                                        input int ht, input int va, input int vss, input int vsw,
                                        input int vt);
    int h, v;
    logic fs;
    h  = t % ht;
    v  = (t / ht) % vt;
`ifdef VGA_FRAME_START_EN
    fs = (t > 0) && (h == 0) && (v == 0);
`else
    fs = 1'b0;
`endif
    return {fs, (v >= va), (v >= vss && v < vss + vsw), (h >= ha),
            (h >= hss && h < hss + hsw), 12'(v), 12'(h)};
  endfunction

  int   t_model = 0;
  logic model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t_model     <= 0;
      model_valid <= 1'b1;
    end else begin
      t_model <= t_model + 1;
    end
  end

  always @(negedge clk) begin
    logic [28:0] ex, es;
    if (model_valid) begin
      ex = model(t_model, 1024, 1048, 136, 1344, 768, 771, 6, 806);
      es = model(t_model, SH_ACT, SH_SS, SH_SW, SH_TOT, SV_ACT, SV_SS, SV_SW, SV_TOT);
      n_checks++;
      if (act_x !== ex) begin
        n_fail++;
        $display("FAIL xga_cycle t=%0d: got %h, expected %h", t_model, act_x, ex);
        if (n_fail >= 200) finish_up();
      end
      n_checks++;
      if (act_s !== es) begin
        n_fail++;
        $display("FAIL small_cycle t=%0d: got %h, expected %h", t_model, act_s, es);
        if (n_fail >= 200) finish_up();
      end
    end
  end

  initial begin
    int x_hsync_cnt, x_hblnk_cnt;
    int s_vblnk_cnt, s_vsync_cnt, s_hsync_cnt, s_run, s_maxrun;
    int s_zero_cnt, s_zero_first, s_zero_last, s_fs_cnt, s_first_h0;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // First cycle after release: (0,0), all flags clear.
    check("rel_hcount", int'(vga_x.hcount), 0);
    check("rel_vcount", int'(vga_x.vcount), 0);
    check("rel_flags", int'(act_x[28:24]), 0);
    check("rel_small", int'(act_s), 0);

    x_hsync_cnt = 0; x_hblnk_cnt = 0;
    s_vblnk_cnt = 0; s_vsync_cnt = 0; s_hsync_cnt = 0; s_run = 0; s_maxrun = 0;
    s_zero_cnt = 0; s_zero_first = -1; s_zero_last = -1; s_fs_cnt = 0;

    for (int k = 1; k <= 3 * S_FRAME; k++) begin
      @(negedge clk);
      case (k)
        1:    check("x_h_after_rel", int'(vga_x.hcount), 1);
        1023: check("x_hblnk_1023", int'(vga_x.hblnk), 0);
        1024: begin
          check("x_hblnk_1024", int'(vga_x.hblnk), 1);
          check("x_hcount_1024", int'(vga_x.hcount), 1024);
        end
        1047: check("x_hsync_1047", int'(vga_x.hsync), 0);
        1048: check("x_hsync_1048", int'(vga_x.hsync), 1);
        1183: check("x_hsync_1183", int'(vga_x.hsync), 1);
        1184: check("x_hsync_1184", int'(vga_x.hsync), 0);
        1343: begin
          check("x_hcount_last", int'(vga_x.hcount), 1343);
          check("x_vcount_line0", int'(vga_x.vcount), 0);
        end
        1344: begin
          check("x_wrap_hcount", int'(vga_x.hcount), 0);
          check("x_wrap_vcount", int'(vga_x.vcount), 1);
          check("x_wrap_hblnk", int'(vga_x.hblnk), 0);
        end
        1399: begin
          check("s_last_h", int'(vga_s.hcount), 55);
          check("s_last_v", int'(vga_s.vcount), 24);
          check("s_last_flags", int'({vga_s.vblnk, vga_s.vsync, vga_s.hblnk, vga_s.hsync}), 4'b1110);
        end
        1400: check("s_frame_wrap", int'({vga_s.vcount, vga_s.hcount}), 0);
        default: ;
      endcase
      if (k >= 1344 && k < 2688) begin
        x_hsync_cnt += int'(vga_x.hsync);
        x_hblnk_cnt += int'(vga_x.hblnk);
      end
      if (k >= S_FRAME && k < 2 * S_FRAME) begin
        s_vblnk_cnt += int'(vga_s.vblnk);
        s_vsync_cnt += int'(vga_s.vsync);
        s_hsync_cnt += int'(vga_s.hsync);
        s_run = vga_s.vsync ? s_run + 1 : 0;
        if (s_run > s_maxrun) s_maxrun = s_run;
      end
      if (vga_s.hcount == 12'd0 && vga_s.vcount == 12'd0) begin
        s_zero_cnt++;
        if (s_zero_first < 0) s_zero_first = k;
        s_zero_last = k;
      end
      s_fs_cnt += int'(fs_s);
    end

    check("x_hsync_per_line", x_hsync_cnt, 136);
    check("x_hblnk_per_line", x_hblnk_cnt, 320);
    check("s_vblnk_per_frame", s_vblnk_cnt, 5 * SH_TOT);
    check("s_vsync_per_frame", s_vsync_cnt, SV_SW * SH_TOT);
    check("s_vsync_run", s_maxrun, SV_SW * SH_TOT);
    check("s_hsync_per_frame", s_hsync_cnt, SH_SW * SV_TOT);
    check("s_zero_count", s_zero_cnt, 3);
    check("s_zero_first", s_zero_first, S_FRAME);
    check("s_zero_last", s_zero_last, 3 * S_FRAME);
`ifdef VGA_FRAME_START_EN
    check("s_fs_count", s_fs_cnt, 3);
`endif

    // Walk to mid-frame (h=30, v=12) then reset for a single edge.
    repeat (12 * SH_TOT + 30) @(negedge clk);
    check("s_mid_h", int'(vga_s.hcount), 30);
    check("s_mid_v", int'(vga_s.vcount), 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_small", int'(act_s), 0);
    check("mid_rst_xga", int'(act_x), 0);

    s_zero_cnt = 0; s_zero_first = -1; s_fs_cnt = 0; s_first_h0 = -1;
    for (int k = 1; k <= 2 * S_FRAME; k++) begin
      @(negedge clk);
      if (k == 1344) begin
        check("x_post_rst_h", int'(vga_x.hcount), 0);
        check("x_post_rst_v", int'(vga_x.vcount), 1);
      end
      if (s_first_h0 < 0 && vga_s.hcount == 12'd0) begin
        s_first_h0 = k;
        check("s_post_rst_line_v", int'(vga_s.vcount), 1);
      end
      if (vga_s.hcount == 12'd0 && vga_s.vcount == 12'd0) begin
        s_zero_cnt++;
        if (s_zero_first < 0) s_zero_first = k;
      end
      s_fs_cnt += int'(fs_s);
    end
    check("s_post_rst_line_len", s_first_h0, SH_TOT);
    check("s_post_rst_frame_len", s_zero_first, S_FRAME);
    check("s_post_rst_zero_cnt", s_zero_cnt, 2);
`ifdef VGA_FRAME_START_EN
    check("s_post_rst_fs_cnt", s_fs_cnt, 2);
`endif

    @(negedge clk);
    finish_up();
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running XGA (1024x768 @ 60 Hz, 65 MHz pixel clock) raster timing generator.
- Directly upstream of the background-draw stage. Drives that stage's vcount/vsync/vblnk/hcount/hsync/hblnk inputs.
- All outputs are registered and mutually aligned: sync and blank flags in any cycle describe the count values presented in that same cycle.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_SYNC_START, 1048, first hcount with hsync asserted
- H_SYNC_WIDTH, 136, hsync pulse length in pixels
- H_TOTAL, 1344, pixels per line including blanking
- V_ACTIVE, 768, visible lines per frame
- V_SYNC_START, 771, first vcount with vsync asserted
- V_SYNC_WIDTH, 6, vsync pulse length in lines
- V_TOTAL, 806, lines per frame including blanking

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-high reset
- vcount  out  12  current line, 0..V_TOTAL-1
- vsync  out  1  vertical sync, active-high
- vblnk  out  1  vertical blanking, high for lines V_ACTIVE..V_TOTAL-1
- hcount  out  12  current pixel, 0..H_TOTAL-1
- hsync  out  1  horizontal sync, active-high
- hblnk  out  1  horizontal blanking, high for pixels H_ACTIVE..H_TOTAL-1
- frame_start  out  1  present only with VGA_FRAME_START_EN (see Optional Feature)

Behaviour:
- Reset (rst high at posedge clk): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0. Reset has priority over counting and can be asserted mid-frame. The first cycle after release presents (0,0). Counting resumes on the next edge.
- Horizontal counter: hcount increments by 1 every clk. At H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter: vcount increments only on the edge where hcount wraps (1343->0). At V_TOTAL-1 with hcount=H_TOTAL-1, both wrap to 0 on the same edge.
- Flag outputs are computed from the next-state count values and registered alongside the counts, so there is zero skew between counts and flags.
  - hblnk = (hcount >= H_ACTIVE)
  - hsync = (H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_WIDTH), i.e. pixels 1048..1183
  - vblnk = (vcount >= V_ACTIVE)
  - vsync = (V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_WIDTH), i.e. lines 771..776, spanning whole lines
- Arithmetic: 12-bit unsigned compares. Counts never exceed TOTAL-1. There is no other state.
- Polarity: sync outputs are active-high internally. The top level inverts them at the pins, as XGA requires negative polarity.
- Frame period: exactly H_TOTAL*V_TOTAL = 1,083,264 clocks. Line period: exactly 1344 clocks.
- Downstream stages add their own registered delay. This block compensates for none of it.

Optional Feature:
- Macro: VGA_FRAME_START_EN.
- Defined: adds output frame_start.
  - High for exactly one clk in the cycle where hcount=0 and vcount=0 are presented, registered with the counts.
  - Not asserted in the first cycle after reset release.
  - First assertion is at the first natural wrap.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Reset release: rst high 5 clks then low -> first cycle shows hcount=0, vcount=0, all flags 0. Next cycle hcount=1.
- Line timing: run 2 lines -> hblnk rises when hcount=1024 and falls at hcount=0. hsync high for hcount 1048..1183 (136 clks). Line length 1344 clks.
- Line/frame wrap: observe hcount 1343->0 with vcount n->n+1. At (1343,805) the next cycle is (0,0).
- Vertical flags: full frame -> vblnk high for vcount 768..805. vsync high for lines 771..776 = 6*1344 = 8064 consecutive clks. Frame = 1,083,264 clks.
- Reset mid-frame: assert rst at hcount=500, vcount=300 for 1 clk -> next cycle (0,0), flags 0. Line and frame lengths after release are nominal.
- With VGA_FRAME_START_EN: frame_start pulses exactly once per 1,083,264 clks, coincident with (0,0). No pulse directly after reset release.
